// File: rtl/loader_pkg.sv
// Shared types and encodings for the operand loader front end.
// Pure declarations: no latency, no flow control.
package loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        ISSUE,
        WAIT_RES,
        SHOW
    } state_t;

    localparam logic [1:0] PH_LOAD_A = 2'd0;
    localparam logic [1:0] PH_LOAD_B = 2'd1;
    localparam logic [1:0] PH_BUSY   = 2'd2;
    localparam logic [1:0] PH_SHOW   = 2'd3;

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and falling-edge-detects the active-low enter button.
// Press pulse appears DEBOUNCE_CYCLES+2 cycles after a stable low level; no backpressure.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic nenter,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Released level is 1, so all conditioning state resets to "not pressed".
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_deb   <= 1'b1;
            r_deb_d <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= nenter;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_press <= r_deb_d & ~r_deb;
            if (r_sync2 != r_deb) begin
                if (r_cnt == CNT_LAST) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/operand_loader.sv
// Assembles operands A and B from button-entered bytes, issues them, then steps result bytes.
// Outputs registered; operands held while ops_valid waits on ops_ready; presses in BUSY are dropped.
module operand_loader
    import loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BYTES_PER_OP    = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              nenter,
    input  logic [BYTE_W-1:0] inputdata,
    output logic [WORD_W-1:0] opa,
    output logic [WORD_W-1:0] opb,
    output logic              ops_valid,
    input  logic              ops_ready,
    input  logic              result_valid,
    output logic [1:0]        result_sel,
    output logic [1:0]        phase,
    output logic [1:0]        byte_idx
);

    generate
        if (BYTES_PER_OP != 4) begin : g_bad_bytes
            $error("operand_loader: BYTES_PER_OP must be 4");
        end
    endgenerate

    logic w_press;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
        .clk    (clk),
        .nreset (nreset),
        .nenter (nenter),
        .press  (w_press)
    );

    state_t            r_state;
    logic [WORD_W-1:0] r_opa;
    logic [WORD_W-1:0] r_opb;
    logic              r_ops_valid;
    logic [1:0]        r_result_sel;
    logic [1:0]        r_phase;
    logic [1:0]        r_byte_idx;

    // Most significant byte first: entry 0 lands in bits [31:24].
    logic [1:0] w_lane;
    logic [4:0] w_lsb;
    assign w_lane = 2'd3 - r_byte_idx;
    assign w_lsb  = {w_lane, 3'b000};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= LOAD_A;
            r_opa        <= '0;
            r_opb        <= '0;
            r_ops_valid  <= 1'b0;
            r_result_sel <= 2'd3;
            r_phase      <= PH_LOAD_A;
            r_byte_idx   <= 2'd0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_press) begin
                        r_opa[w_lsb +: BYTE_W] <= inputdata;
                        r_byte_idx             <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state <= LOAD_B;
                            r_phase <= PH_LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_press) begin
                        r_opb[w_lsb +: BYTE_W] <= inputdata;
                        r_byte_idx             <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state     <= ISSUE;
                            r_phase     <= PH_BUSY;
                            r_ops_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // A coincident result_valid is deliberately dropped here.
                    if (r_ops_valid && ops_ready) begin
                        r_ops_valid <= 1'b0;
                        r_state     <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (result_valid) begin
                        r_state      <= SHOW;
                        r_phase      <= PH_SHOW;
                        r_result_sel <= 2'd3;
                    end
                end
                SHOW: begin
                    if (w_press) begin
                        if (r_result_sel == 2'd0) begin
                            r_state      <= LOAD_A;
                            r_phase      <= PH_LOAD_A;
                            r_result_sel <= 2'd3;
                            r_byte_idx   <= 2'd0;
                            r_opa        <= '0;
                            r_opb        <= '0;
                        end else begin
                            r_result_sel <= r_result_sel - 2'd1;
                        end
                    end
                end
                default: begin
                    r_state      <= LOAD_A;
                    r_phase      <= PH_LOAD_A;
                    r_ops_valid  <= 1'b0;
                    r_result_sel <= 2'd3;
                    r_byte_idx   <= 2'd0;
                end
            endcase
        end
    end

    assign opa        = r_opa;
    assign opb        = r_opb;
    assign ops_valid  = r_ops_valid;
    assign result_sel = r_result_sel;
    assign phase      = r_phase;
    assign byte_idx   = r_byte_idx;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed scenarios plus randomized button/handshake traffic,
// all outputs compared every cycle against a behavioural model of the button and entry flow.
module tb_operand_loader;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        nenter = 1'b1;
    logic [7:0]  inputdata = 8'h00;
    logic        ops_ready = 1'b0;
    logic        result_valid = 1'b0;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        ops_valid;
    logic [1:0]  result_sel;
    logic [1:0]  phase;
    logic [1:0]  byte_idx;

    operand_loader #(
        .DEBOUNCE_CYCLES(D),
        .BYTES_PER_OP   (4)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .nenter       (nenter),
        .inputdata    (inputdata),
        .opa          (opa),
        .opb          (opb),
        .ops_valid    (ops_valid),
        .ops_ready    (ops_ready),
        .result_valid (result_valid),
        .result_sel   (result_sel),
        .phase        (phase),
        .byte_idx     (byte_idx)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. Button: the debounced level flips once the last D synchronized
    // samples all disagree with it; a 1->0 flip yields a press one cycle later.
    logic        m_sh [0:D];
    logic        m_deb;
    logic        m_fell;
    logic        m_press;
    int          m_mode;  // 0 A, 1 B, 2 issue, 3 wait, 4 show
    int          m_n;
    int          m_sel;
    logic [31:0] m_a;
    logic [31:0] m_b;

    task automatic model_reset();
        for (int i = 0; i <= D; i++) m_sh[i] = 1'b1;
        m_deb   = 1'b1;
        m_fell  = 1'b0;
        m_press = 1'b0;
        m_mode  = 0;
        m_n     = 0;
        m_sel   = 3;
        m_a     = 32'h0;
        m_b     = 32'h0;
    endtask

    task automatic model_step();
        logic        p;
        bit          all_diff;
        int          sh8;
        logic [31:0] mask;
        logic [31:0] val;
        p = m_press;
        all_diff = 1'b1;
        for (int i = 1; i <= D; i++) if (m_sh[i] == m_deb) all_diff = 1'b0;
        m_press = m_fell;
        m_fell  = 1'b0;
        if (all_diff) begin
            if (m_deb == 1'b1) m_fell = 1'b1;
            m_deb = ~m_deb;
        end
        for (int i = D; i > 0; i--) m_sh[i] = m_sh[i-1];
        m_sh[0] = nenter;

        sh8  = 8 * (3 - m_n);
        mask = 32'hFF << sh8;
        val  = {24'h0, inputdata} << sh8;
        case (m_mode)
            0, 1: if (p) begin
                if (m_mode == 0) m_a = (m_a & ~mask) | val;
                else             m_b = (m_b & ~mask) | val;
                if (m_n == 3) begin
                    m_n = 0;
                    m_mode = m_mode + 1;
                end else begin
                    m_n = m_n + 1;
                end
            end
            2: if (ops_ready) m_mode = 3;
            3: if (result_valid) begin
                m_mode = 4;
                m_sel  = 3;
            end
            default: if (p) begin
                if (m_sel == 0) begin
                    m_mode = 0;
                    m_sel  = 3;
                    m_n    = 0;
                    m_a    = 32'h0;
                    m_b    = 32'h0;
                end else begin
                    m_sel = m_sel - 1;
                end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge nreset);
            if (!nreset) model_reset();
            else         model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("m_opa",        opa,                 m_a);
                chk("m_opb",        opb,                 m_b);
                chk("m_ops_valid",  32'(ops_valid),      32'(m_mode == 2));
                chk("m_phase",      32'(phase),          (m_mode < 2) ? m_mode : ((m_mode < 4) ? 2 : 3));
                chk("m_byte_idx",   32'(byte_idx),       m_n);
                chk("m_result_sel", 32'(result_sel),     m_sel);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input logic [7:0] d);
        inputdata = d;
        nenter = 1'b0;
        cyc(10);
        nenter = 1'b1;
        cyc(10);
    endtask

    int lo;
    int hi;

    initial begin
        cyc(3);
        nreset = 1'b1;
        cyc(1);
        cmp_on = 1'b1;
        chk("rst_opa",        opa,             32'h0);
        chk("rst_ops_valid",  32'(ops_valid),  32'h0);
        chk("rst_phase",      32'(phase),      32'h0);
        chk("rst_byte_idx",   32'(byte_idx),   32'h0);
        chk("rst_result_sel", 32'(result_sel), 32'h3);

        // Glitch of 2 cycles is rejected.
        nenter = 1'b0;
        cyc(2);
        nenter = 1'b1;
        cyc(12);
        chk("glitch_byte_idx", 32'(byte_idx), 32'h0);

        // Press latency: low from edge N, press in cycle N+6, byte_idx moves at N+7.
        inputdata = 8'h3F;
        nenter = 1'b0;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        chk("press_cycle_n6",   32'(dut.u_cond.press), 32'h1);
        chk("press_lat_before", 32'(byte_idx),         32'h0);
        @(posedge clk);
        #1;
        chk("press_lat_after",  32'(byte_idx),         32'h1);
        cyc(3);
        nenter = 1'b1;
        cyc(10);

        press_btn(8'h80); chk("a_idx2", 32'(byte_idx), 32'h2);
        press_btn(8'h00); chk("a_idx3", 32'(byte_idx), 32'h3);
        press_btn(8'h00); chk("a_idx0", 32'(byte_idx), 32'h0);
        chk("a_phase", 32'(phase), 32'h1);
        chk("a_opa",   opa,        32'h3F800000);
        press_btn(8'h3F);
        press_btn(8'h80);
        press_btn(8'h00);
        press_btn(8'h00);
        chk("b_opb",       opb,            32'h3F800000);
        chk("b_phase",     32'(phase),     32'h2);
        chk("b_ops_valid", 32'(ops_valid), 32'h1);

        // Handshake stall, then transfer with a coincident result_valid.
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("stall_valid", 32'(ops_valid), 32'h1);
            chk("stall_opa",   opa,            32'h3F800000);
        end
        ops_ready = 1'b1;
        result_valid = 1'b1;
        cyc(1);
        ops_ready = 1'b0;
        result_valid = 1'b0;
        chk("xfer_valid", 32'(ops_valid), 32'h0);
        chk("xfer_phase", 32'(phase),     32'h2);
        cyc(5);
        chk("wait_phase", 32'(phase), 32'h2);
        press_btn(8'hAA);
        chk("wait_press_phase", 32'(phase), 32'h2);
        chk("wait_press_opa",   opa,        32'h3F800000);

        result_valid = 1'b1;
        cyc(1);
        result_valid = 1'b0;
        chk("show_phase", 32'(phase),      32'h3);
        chk("show_sel3",  32'(result_sel), 32'h3);
        press_btn(8'h00); chk("show_sel2", 32'(result_sel), 32'h2);
        press_btn(8'h00); chk("show_sel1", 32'(result_sel), 32'h1);
        press_btn(8'h00); chk("show_sel0", 32'(result_sel), 32'h0);
        press_btn(8'h00);
        chk("ret_phase", 32'(phase),      32'h0);
        chk("ret_opa",   opa,             32'h0);
        chk("ret_opb",   opb,             32'h0);
        chk("ret_sel",   32'(result_sel), 32'h3);

        result_valid = 1'b1;
        cyc(2);
        result_valid = 1'b0;
        cyc(1);
        chk("rv_in_load_a", 32'(phase), 32'h0);

        // Reset mid-LOAD_B with a press in flight.
        press_btn(8'h3F);
        press_btn(8'h80);
        press_btn(8'h00);
        press_btn(8'h00);
        press_btn(8'h12);
        chk("pre_rst_opa", opa, 32'h3F800000);
        nenter = 1'b0;
        cyc(5);
        #2 nreset = 1'b0;
        #1;
        chk("mid_rst_opa",   opa,             32'h0);
        chk("mid_rst_opb",   opb,             32'h0);
        chk("mid_rst_phase", 32'(phase),      32'h0);
        chk("mid_rst_idx",   32'(byte_idx),   32'h0);
        chk("mid_rst_sel",   32'(result_sel), 32'h3);
        chk("mid_rst_vld",   32'(ops_valid),  32'h0);
        nenter = 1'b1;
        cyc(3);
        nreset = 1'b1;
        cyc(20);
        chk("no_ghost_press", 32'(byte_idx), 32'h0);

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            lo = $urandom_range(1, 8);
            hi = $urandom_range(1, 10);
            for (int c = 0; c < lo + hi; c++) begin
                nenter       = (c >= lo);
                inputdata    = 8'($urandom);
                ops_ready    = ($urandom_range(0, 3) == 0);
                result_valid = ($urandom_range(0, 5) == 0);
                cyc(1);
            end
            if ($urandom_range(0, 99) == 0) begin
                #3 nreset = 1'b0;
                cyc(2);
                nreset = 1'b1;
            end
        end
        ops_ready = 1'b0;
        result_valid = 1'b0;
        nenter = 1'b1;
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Front-end stage that conditions the raw active-low enter push-button: 2-flop synchronizer, debounce and falling-edge detect.
- Uses each press to assemble two 32-bit operands, A then B, from four 8-bit switch entries each, most significant byte first.
- Hands the operand pair to the downstream arithmetic datapath over a valid/ready handshake.
- After a result arrives, sequences the result-byte index selected by the display stage; one press advances one byte.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles needed to accept a button level change (minimum 1).
- BYTES_PER_OP, 4: bytes per operand. Fixed at 4; any other value is a compile-time error.

Ports:
- clk  in  1  system clock, rising edge
- nreset  in  1  reset, asynchronous, active-low
- nenter  in  1  raw push-button, active-low, asynchronous to clk
- inputdata  in  8  byte on switches, sampled on an accepted press
- opa  out  32  operand A
- opb  out  32  operand B
- ops_valid  out  1  opa/opb ready for transfer
- ops_ready  in  1  downstream accepts the operands
- result_valid  in  1  one-cycle-or-longer pulse: result available downstream
- result_sel  out  2  result byte index for display, 3 = MSB
- phase  out  2  status for display: 0 LOAD_A, 1 LOAD_B, 2 BUSY (ISSUE or WAIT_RES), 3 SHOW
- byte_idx  out  2  count of bytes already entered in the current operand (0..3)

Behaviour:
- Reset (nreset low, async): state LOAD_A; opa=0, opb=0, ops_valid=0, result_sel=3, byte_idx=0, phase=0. Synchronizer flops reset to 1 (released). Debounced level resets to 1 and the debounce counter to 0.
- Conditioning:
  - sync = 2-flop synchronized nenter.
  - While sync != deb, the counter increments. When it reaches DEBOUNCE_CYCLES, deb <= sync and the counter clears.
  - Any cycle with sync == deb clears the counter.
  - press = one-cycle registered pulse on a deb 1->0 transition.
  - A low level held from clock edge N produces press high in cycle N+2+DEBOUNCE_CYCLES.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no press.
  - Holding the button yields exactly one press; release generates nothing.
- FSM states: LOAD_A, LOAD_B, ISSUE, WAIT_RES, SHOW.
  - LOAD_A: on press, opa[31-8*byte_idx -: 8] <= inputdata and byte_idx increments. A press while byte_idx==3 writes bits [7:0], then byte_idx <= 0 and the state goes to LOAD_B.
  - LOAD_B: same, writing opb. The fourth press goes to ISSUE.
  - ISSUE: ops_valid=1, registered and asserted in the first ISSUE cycle. Transfer occurs on a cycle with ops_valid && ops_ready. In the following cycle ops_valid=0 and the state is WAIT_RES. opa/opb are stable while ops_valid=1.
  - WAIT_RES: on result_valid -> SHOW, result_sel=3.
  - SHOW: each press decrements result_sel. A press with result_sel==0 goes to LOAD_A with result_sel<=3, byte_idx<=0, opa<=0, opb<=0. Four presses therefore show bytes 3,2,1,0 and the fourth returns to entry.
- Presses in ISSUE and WAIT_RES are ignored, with no queuing.
- result_valid outside WAIT_RES is ignored.
- ops_ready outside ISSUE is ignored.
- If result_valid and ops_ready arrive in the same ISSUE cycle, only the transfer is taken; result_valid is not remembered.
- Reset mid-operation aborts immediately to the reset values. A press pending in the conditioner is discarded.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package loader_pkg:
  - state_t enum {LOAD_A, LOAD_B, ISSUE, WAIT_RES, SHOW}
  - BYTE_W=8, WORD_W=32
  - phase encoding constants PH_LOAD_A/PH_LOAD_B/PH_BUSY/PH_SHOW
- Sub-module button_conditioner: clk, nreset, nenter -> press, parameter DEBOUNCE_CYCLES. It holds the synchronizer, debounce counter and edge detect.
- operand_loader contains the FSM, operand registers and index counters.

Test Plan:
- Reset: nreset=0 mid-LOAD_B with opa=0x3F800000 -> immediately opa=0, opb=0, ops_valid=0, phase=0, byte_idx=0, result_sel=3. A press pending at reset never appears.
- Glitch rejection, DEBOUNCE_CYCLES=4: nenter low for 2 cycles, then high -> no press, byte_idx stays 0. Low for 10 cycles -> exactly one press, at cycle N+6.
- Operand entry: presses with 0x3F,0x80,0x00,0x00 twice -> opa=opb=0x3F800000, phase=2, ops_valid=1. byte_idx reads 1,2,3,0 after each press of A.
- Handshake: hold ops_ready=0 for 5 cycles -> ops_valid stays 1 and opa/opb stay stable. Raise ops_ready for 1 cycle -> ops_valid=0 the next cycle, state WAIT_RES. Extra presses there change nothing.
- Result display: result_valid pulse -> phase=3, result_sel=3. Three presses -> result_sel 2,1,0. Fourth press -> phase=0, opa=opb=0, result_sel=3.
- Simultaneous events: result_valid asserted in the same cycle as the ISSUE transfer -> state WAIT_RES, which holds until a later result_valid. result_valid during LOAD_A -> no state change.
